// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with a valid/ready
// handshake on both sides. A two-entry skid buffer (main + skid register)
// lets in_ready come straight from a flop while still sustaining one entry
// per cycle. Adds flush (bubble insertion) and a saturating stall counter.
//
// Ports
//   clk        in   1       rising-edge clock
//   clr        in   1       synchronous reset, active-high
//   flush      in   1       synchronous flush: discard all held entries
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept (registered)
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream entry valid
//   out_ready  in   1       downstream accepts (0 = stall)
//   out_ctrl   out  CTRL_W  control field; 0 whenever out_valid = 0
//   out_data   out  DATA_W  payload; holds last value when out_valid = 0
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 96,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [CNT_W-1:0]  stall_q;

   logic in_xfer;
   logic out_xfer;
   logic stall_evt;

   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid_q & out_ready;
   assign stall_evt = out_valid_q & ~out_ready;

   // in_ready and out_valid are kept as their own flops (rather than decoded
   // from state) so neither handshake output has logic after the register.
   always_ff @(posedge clk) begin
      // NOTE: all state here is updated with non-blocking assignments so every
      // register samples pre-edge values; the skid register is a plain flop,
      // not a memory, so it is cheap to clear on clr.
      if (clr) begin
         state       <= EMPTY;
         main_ctrl   <= '0;
         main_data   <= '0;
         skid_ctrl   <= '0;
         skid_data   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         // Counted on the pre-edge handshake, so a flush cycle still counts
         // when the stage was stalled going into it.
         if (stall_evt && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);

         if (flush) begin
            // Bubble: control zeroed, payload left alone.
            state       <= EMPTY;
            main_ctrl   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_xfer) begin
                     state       <= ONE;
                     main_ctrl   <= in_ctrl;
                     main_data   <= in_data;
                     out_valid_q <= 1'b1;
                  end
               end
               ONE: begin
                  if (in_xfer && out_xfer) begin
                     main_ctrl <= in_ctrl;
                     main_data <= in_data;
                  end else if (in_xfer) begin
                     // Downstream stalled: park the new entry behind main.
                     state      <= FULL;
                     skid_ctrl  <= in_ctrl;
                     skid_data  <= in_data;
                     in_ready_q <= 1'b0;
                  end else if (out_xfer) begin
                     state       <= EMPTY;
                     main_ctrl   <= '0;
                     out_valid_q <= 1'b0;
                  end
               end
               FULL: begin
                  if (out_xfer) begin
                     state      <= ONE;
                     main_ctrl  <= skid_ctrl;
                     main_data  <= skid_data;
                     in_ready_q <= 1'b1;
                  end
               end
               default: begin
                  state       <= EMPTY;
                  main_ctrl   <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Self-checking bench for pipe_stage_skid. A reference queue holds the
// entries the stage should be carrying; its depth gives the expected
// in_ready/out_valid, its head gives the expected output entry. A second
// instance with CNT_W = 2 shares all inputs to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int CTRL_W = 8;
   localparam int DATA_W = 96;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              clk = 1'b0;
   logic              clr;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;

   logic              in_ready_s;
   logic              out_valid_s;
   logic [CTRL_W-1:0] out_ctrl_s;
   logic [DATA_W-1:0] out_data_s;
   logic [1:0]        stall_cnt_s;

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s),
      .out_data(out_data_s), .stall_cnt(stall_cnt_s)
   );

   always #5 clk = ~clk;

   entry_t            sb[$];
   logic [DATA_W-1:0] last_data;
   logic [CNT_W-1:0]  exp_stall;
   logic [1:0]        exp_stall2;
   bit                chk_en;
   int                n_chk;
   int                n_pass;

   function automatic entry_t mk(input int i);
      entry_t e;
      e.ctrl = CTRL_W'(i + 1);
      e.data = {32'(i) * 32'h0101_0101, 32'hDEAD_0000 | 32'(i), 32'(i)};
      return e;
   endfunction

   task automatic drive(input logic v, input entry_t e);
      in_valid = v;
      in_ctrl  = e.ctrl;
      in_data  = e.data;
   endtask

   // Compare outputs to the model, then advance model and DUT by one edge.
   task automatic cycle();
      logic   exp_ov;
      logic   exp_ir;
      entry_t exp_e;
      exp_ov = (sb.size() > 0);
      exp_ir = (sb.size() < 2);
      exp_e  = exp_ov ? sb[0] : '{ctrl: '0, data: last_data};
      if (chk_en) begin
         n_chk++;
         if (out_valid !== exp_ov) $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov);
         else n_pass++;
         n_chk++;
         if (in_ready !== exp_ir) $display("FAIL in_ready: got %b expected %b", in_ready, exp_ir);
         else n_pass++;
         n_chk++;
         if (out_ctrl !== exp_e.ctrl) $display("FAIL out_ctrl: got %h expected %h", out_ctrl, exp_e.ctrl);
         else n_pass++;
         n_chk++;
         if (out_data !== exp_e.data) $display("FAIL out_data: got %h expected %h", out_data, exp_e.data);
         else n_pass++;
         n_chk++;
         if (stall_cnt !== exp_stall) $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
         else n_pass++;
         n_chk++;
         if (stall_cnt_s !== exp_stall2) $display("FAIL stall_cnt_sat: got %0d expected %0d", stall_cnt_s, exp_stall2);
         else n_pass++;
         n_chk++;
         if ({out_valid_s, in_ready_s, out_ctrl_s, out_data_s} !== {exp_ov, exp_ir, exp_e.ctrl, exp_e.data})
            $display("FAIL sat_outputs: got %b/%b/%h/%h expected %b/%b/%h/%h", out_valid_s, in_ready_s,
                     out_ctrl_s, out_data_s, exp_ov, exp_ir, exp_e.ctrl, exp_e.data);
         else n_pass++;
      end
      if (exp_ov && !out_ready) begin
         if (exp_stall != {CNT_W{1'b1}}) exp_stall++;
         if (exp_stall2 != 2'b11) exp_stall2++;
      end
      if (clr) begin
         sb.delete();
         last_data  = '0;
         exp_stall  = '0;
         exp_stall2 = '0;
      end else if (flush) begin
         sb.delete();
      end else begin
         if (exp_ov && out_ready) void'(sb.pop_front());
         if (in_valid && exp_ir) sb.push_back('{ctrl: in_ctrl, data: in_data});
      end
      if (sb.size() > 0) last_data = sb[0].data;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      chk_en    = 1'b0;
      clr       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, mk(99));
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b0;
      drive(1'b0, mk(0));
      out_ready  = 1'b1;
      sb.delete();
      last_data  = '0;
      exp_stall  = '0;
      exp_stall2 = '0;
      chk_en     = 1'b1;
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else n_pass++;
      n_chk++;
      if (out_ctrl !== '0) $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl);
      else n_pass++;
      n_chk++;
      if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data);
      else n_pass++;
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      else n_pass++;
      n_chk++;
      if (stall_cnt !== '0 || stall_cnt_s !== '0)
         $display("FAIL reset_stall_cnt: got %0d/%0d expected 0/0", stall_cnt, stall_cnt_s);
      else n_pass++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(10 + i));
         cycle();
         n_chk++;
         if (out_valid !== 1'b1 || out_data !== mk(10 + i).data || in_ready !== 1'b1)
            $display("FAIL stream_%0d: got v=%b r=%b d=%h expected v=1 r=1 d=%h",
                     i, out_valid, in_ready, out_data, mk(10 + i).data);
         else n_pass++;
      end
      drive(1'b0, mk(0));
      cycle();
      n_chk++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== mk(12).data)
         $display("FAIL stream_bubble: got v=%b c=%h d=%h expected v=0 c=0 d=%h",
                  out_valid, out_ctrl, out_data, mk(12).data);
      else n_pass++;
   endtask

   task automatic test_stall();
      logic [CNT_W-1:0] s0;
      s0 = exp_stall;
      out_ready = 1'b0;
      drive(1'b1, mk(20));
      cycle();
      drive(1'b1, mk(21));
      cycle();
      drive(1'b0, mk(0));
      n_chk++;
      if (in_ready !== 1'b0 || out_data !== mk(20).data)
         $display("FAIL stall_full: got r=%b d=%h expected r=0 d=%h", in_ready, out_data, mk(20).data);
      else n_pass++;
      cycle();
      out_ready = 1'b1;
      cycle();
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== mk(21).data || in_ready !== 1'b1)
         $display("FAIL stall_release: got v=%b r=%b d=%h expected v=1 r=1 d=%h",
                  out_valid, in_ready, out_data, mk(21).data);
      else n_pass++;
      cycle();
      n_chk++;
      if (stall_cnt !== s0 + CNT_W'(2))
         $display("FAIL stall_count: got %0d expected %0d", stall_cnt, s0 + CNT_W'(2));
      else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, mk(30));
      cycle();
      drive(1'b1, mk(31));
      cycle();
      flush = 1'b1;
      drive(1'b1, mk(32));
      cycle();
      flush = 1'b0;
      drive(1'b0, mk(0));
      n_chk++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1)
         $display("FAIL flush: got v=%b c=%h r=%b expected v=0 c=0 r=1", out_valid, out_ctrl, in_ready);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_chk++;
         if (out_valid !== 1'b0) $display("FAIL flush_ghost_%0d: got v=%b expected 0", i, out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int exp_tab[6];
      exp_tab = '{1, 2, 3, 3, 3, 3};
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, mk(40));
      cycle();
      drive(1'b0, mk(0));
      for (int i = 0; i < 6; i++) begin
         cycle();
         n_chk++;
         if (stall_cnt_s !== 2'(exp_tab[i]) || stall_cnt !== CNT_W'(i + 1))
            $display("FAIL saturate_%0d: got %0d/%0d expected %0d/%0d",
                     i, stall_cnt_s, stall_cnt, exp_tab[i], i + 1);
         else n_pass++;
      end
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_random();
      entry_t e;
      for (int i = 0; i < 10000; i++) begin
         e.ctrl    = CTRL_W'($urandom_range(1, (1 << CTRL_W) - 1));
         e.data    = {$urandom, $urandom, $urandom};
         drive(($urandom % 100) < 60, e);
         out_ready = ($urandom % 100) < 55;
         flush     = ($urandom % 100) == 0;
         clr       = ($urandom % 500) == 0;
         cycle();
      end
      clr       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, mk(0));
      for (int i = 0; i < 4; i++) cycle();
      n_chk++;
      if (sb.size() != 0 || out_valid !== 1'b0)
         $display("FAIL random_drain: got pending=%0d v=%b expected 0/0", sb.size(), out_valid);
      else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
